pixel_result_queue: RTL and testbench

//  Result buffer downstream of the escape-time calc engine. Captures one iteration count per pixel,

---
 rtl/pixel_result_queue_if.sv | 29 ++
 rtl/pixel_result_queue.sv | 125 ++++++++++++
 tb/tb_pixel_result_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_result_queue_if.sv
// Write/stream bundle for pixel_result_queue. The queue connects via the master modport
// and the calc engine / pixel consumer side via the slave modport.
interface pixel_result_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_iter;
    logic              full_queue;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eol;
    logic [CW-1:0]     count;
    logic [15:0]       ovf_count;

    modport master (
        input  wr_en, wr_iter, out_ready,
        output full_queue, out_data, out_valid, out_sof, out_eol, count, ovf_count
    );

    modport slave (
        output wr_en, wr_iter, out_ready,
        input  full_queue, out_data, out_valid, out_sof, out_eol, count, ovf_count
    );
endinterface

// File: rtl/pixel_result_queue.sv
// First-word-fall-through result FIFO with sof/eol pixel tagging and registered almost-full.
// Define PIXEL_QUEUE_OVF_CNT_EN to build the saturating dropped-write counter.
module pixel_result_queue #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480
) (
    input  logic clk,
    input  logic rst,
    pixel_result_queue_if.master q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(DEPTH - AF_MARGIN);
    localparam logic [XW-1:0] X_LAST  = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(Y_SIZE - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;

    logic out_valid;
    logic pop;
    logic push;
    logic store_full;

    assign out_valid  = (count_q != '0);
    assign store_full = (count_q == DEPTH_C);
    assign pop        = out_valid & q.out_ready;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign push       = q.wr_en & (~store_full | pop);

    // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        x_d      = x_q;
        y_d      = y_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // Registered from next-count so it moves in the same cycle as count.
        full_d = (count_d >= AF_C);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= q.wr_iter;
    end

`ifdef PIXEL_QUEUE_OVF_CNT_EN
    logic [15:0] ovf_q, ovf_d;
    logic        drop;

    assign drop = q.wr_en & store_full & ~pop;

    always_comb begin
        ovf_d = ovf_q;
        if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= '0;
        else     ovf_q <= ovf_d;
    end

    assign q.ovf_count = ovf_q;
`else
    assign q.ovf_count = 16'h0000;
`endif

    assign q.out_valid  = out_valid;
    assign q.out_data   = mem_q[rd_ptr_q];
    assign q.out_sof    = out_valid & (x_q == '0) & (y_q == '0);
    assign q.out_eol    = out_valid & (x_q == X_LAST);
    assign q.count      = count_q;
    assign q.full_queue = full_q;

endmodule

// File: tb/tb_pixel_result_queue.sv
// Directed bench for pixel_result_queue (DEPTH=16, AF_MARGIN=2, X_SIZE=4, Y_SIZE=2).
module tb_pixel_result_queue;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    byte  unsigned exp_q[$];
    logic [15:0] ovf_exp;

    pixel_result_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) q_if ();

    pixel_result_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(2), .X_SIZE(4), .Y_SIZE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q  (q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] iter;
        logic       ready;
        int         exp_count;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_sof;
        logic       exp_eol;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr_en, input logic [7:0] iter, input logic ready);
        q_if.wr_en     = wr_en;
        q_if.wr_iter   = iter;
        q_if.out_ready = ready;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        `ifdef PIXEL_QUEUE_OVF_CNT_EN
        ovf_exp = 16'd3;
        `else
        ovf_exp = 16'd0;
        `endif

        // Pixel stream of 9 values through a 4x2 frame: eol on 3 and 7, sof on 0 and 8.
        vecs[0] = '{1'b1, 8'd0, 1'b1, 1, 1'b1, 8'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'd1, 1'b1, 1, 1'b1, 8'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'd2, 1'b1, 1, 1'b1, 8'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'd3, 1'b1, 1, 1'b1, 8'd3, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'd4, 1'b1, 1, 1'b1, 8'd4, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'd5, 1'b1, 1, 1'b1, 8'd5, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'd6, 1'b1, 1, 1'b1, 8'd6, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'd7, 1'b1, 1, 1'b1, 8'd7, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 8'd8, 1'b1, 1, 1'b1, 8'd8, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 8'd0, 1'b1, 0, 1'b0, 8'd0, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        // Reset state
        step();
        step();
        check("rst_count", 32'(q_if.count), 0);
        check("rst_valid", 32'(q_if.out_valid), 0);
        check("rst_full",  32'(q_if.full_queue), 0);
        check("rst_sof",   32'(q_if.out_sof), 0);
        check("rst_eol",   32'(q_if.out_eol), 0);
        check("rst_ovf",   32'(q_if.ovf_count), 0);
        rst = 1'b0;
        step();
        check("post_rst_valid", 32'(q_if.out_valid), 0);

        // 14 writes with the consumer stalled: full_queue rises with the 14th
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            exp_q.push_back(8'(8'h10 + i));
            step();
            check($sformatf("fill_count_%0d", i), 32'(q_if.count), 32'(i + 1));
            check($sformatf("fill_full_%0d", i), 32'(q_if.full_queue), 32'(i + 1 >= 14));
        end
        check("fill_head", 32'(q_if.out_data), 32'h10);
        check("fill_sof",  32'(q_if.out_sof), 1);
        check("fill_eol",  32'(q_if.out_eol), 0);

        // Fill to 16, then 3 dropped writes
        for (int i = 14; i < 16; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            exp_q.push_back(8'(8'h10 + i));
            step();
        end
        check("full_count", 32'(q_if.count), 16);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b0);
            step();
            check($sformatf("drop_count_%0d", i), 32'(q_if.count), 16);
            check($sformatf("drop_head_%0d", i), 32'(q_if.out_data), 32'h10);
        end
        check("drop_ovf", 32'(q_if.ovf_count), 32'(ovf_exp));

        // Full with simultaneous write and pop: writes accepted, count stays 16
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b1);
            exp_q.push_back(8'(8'h20 + i));
            check($sformatf("pp_data_%0d", i), 32'(q_if.out_data), 32'(exp_q.pop_front()));
            check($sformatf("pp_sof_%0d", i), 32'(q_if.out_sof), 32'(i == 0));
            check($sformatf("pp_eol_%0d", i), 32'(q_if.out_eol), 32'(i == 3));
            step();
            check($sformatf("pp_count_%0d", i), 32'(q_if.count), 16);
        end
        check("pp_ovf", 32'(q_if.ovf_count), 32'(ovf_exp));

        // Drain the remaining 16 entries; head pixels 4..19 of a 4x2 frame
        for (int k = 0; k < 16; k++) begin
            int p;
            p = 4 + k;
            drive(1'b0, 8'h00, 1'b1);
            check($sformatf("drain_data_%0d", k), 32'(q_if.out_data), 32'(exp_q.pop_front()));
            check($sformatf("drain_sof_%0d", k), 32'(q_if.out_sof), 32'((p % 4 == 0) && ((p / 4) % 2 == 0)));
            check($sformatf("drain_eol_%0d", k), 32'(q_if.out_eol), 32'(p % 4 == 3));
            step();
        end
        check("drain_count", 32'(q_if.count), 0);
        check("drain_valid", 32'(q_if.out_valid), 0);
        check("drain_full",  32'(q_if.full_queue), 0);

        // Fresh frame, then the table-driven 9-pixel stream
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        rst = 1'b0;
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].wr_en, vecs[v].iter, vecs[v].ready);
            step();
            check($sformatf("vec%0d_count", v), 32'(q_if.count), 32'(vecs[v].exp_count));
            check($sformatf("vec%0d_valid", v), 32'(q_if.out_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_sof", v),   32'(q_if.out_sof), 32'(vecs[v].exp_sof));
            check($sformatf("vec%0d_eol", v),   32'(q_if.out_eol), 32'(vecs[v].exp_eol));
            if (vecs[v].exp_valid)
                check($sformatf("vec%0d_data", v), 32'(q_if.out_data), 32'(vecs[v].exp_data));
        end

        // Reset mid-drain with 5 entries held and the head away from (0,0)
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b1);
        step();
        step();
        check("mid_count", 32'(q_if.count), 5);
        check("mid_sof",   32'(q_if.out_sof), 0);
        rst = 1'b1;
        step();
        check("mrst_count", 32'(q_if.count), 0);
        check("mrst_valid", 32'(q_if.out_valid), 0);
        check("mrst_full",  32'(q_if.full_queue), 0);
        check("mrst_ovf",   32'(q_if.ovf_count), 0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        step();
        check("mrst_post_valid", 32'(q_if.out_valid), 0);
        drive(1'b1, 8'h55, 1'b0);
        step();
        check("mrst_w_valid", 32'(q_if.out_valid), 1);
        check("mrst_w_data",  32'(q_if.out_data), 32'h55);
        check("mrst_w_sof",   32'(q_if.out_sof), 1);
        check("mrst_w_eol",   32'(q_if.out_eol), 0);
        check("mrst_w_count", 32'(q_if.count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
